mux_arb_nto1: RTL and testbench
===============================

MUX_ARB_NTO1 -- requirements
Module: mux_arb_nto1

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24: data width of each channel, matching the CPU datapath.
REQ-002 The block SHALL have parameter N, default 4: number of input channels, N >= 2; IW = max(1, clog2(N)).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; all state updates on the rising edge of Clock.
REQ-004 Clock  input  1  sole clock.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Hyrja  input  N*WIDTH  channel data, flattened; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 HyrjaValid  input  N  per-channel valid.
REQ-008 HyrjaReady  output  N  per-channel ready; combinational.
REQ-009 S  input  IW  channel select, used in fixed mode only.
REQ-010 Mode  input  1  0 = fixed select by S; 1 = round-robin over valid channels.
REQ-011 Dalja  output  WIDTH  registered selected data.
REQ-012 DaljaValid  output  1  Dalja holds an unconsumed word.
REQ-013 DaljaReady  input  1  downstream accepts Dalja this cycle.
REQ-014 DaljaIndex  output  IW  channel index that produced the current Dalja.

Function
REQ-015 A transfer on any port SHALL occur only in a cycle where that port's valid and ready are both high at the rising edge.
REQ-016 Load enable SHALL be LE = !DaljaValid | DaljaReady, so a full output register that drains in a cycle can be refilled in that same cycle.
REQ-017 Fixed mode: grant SHALL be channel S when HyrjaValid[S] = 1 and LE = 1; other channels SHALL see HyrjaReady = 0.
REQ-018 Fixed mode: S >= N SHALL grant no channel, and all HyrjaReady SHALL be 0.
REQ-019 Round-robin mode: grant SHALL be the first channel with HyrjaValid = 1, searching from pointer P upward and wrapping from N-1 to 0.
REQ-020 Round-robin mode: after each accepted transfer, P SHALL become (granted index + 1) mod N; otherwise P SHALL hold.
REQ-021 P SHALL not change in fixed mode.
REQ-022 HyrjaReady[i] SHALL be grant[i] & LE; at most one bit of HyrjaReady SHALL be high in any cycle.
REQ-023 On accept, the block SHALL register the granted channel's data into Dalja and its index into DaljaIndex, and set DaljaValid = 1.
REQ-024 Latency SHALL be 1 cycle from input transfer to DaljaValid; sustained throughput SHALL be 1 word/cycle while DaljaReady = 1.
REQ-025 When DaljaReady = 1 and no grant occurs, DaljaValid SHALL go to 0 on the next edge.
REQ-026 While DaljaValid = 1 and DaljaReady = 0, Dalja and DaljaIndex SHALL hold, and all HyrjaReady SHALL be 0.
REQ-027 A Mode or S change SHALL affect only the grant of the current cycle and SHALL NOT alter an already registered word.
REQ-028 Data on a channel that is not accepted SHALL NOT be dropped or reordered; this block does no buffering on the input side.

Reset
REQ-029 When Reset = 1 at an edge, DaljaValid, Dalja, DaljaIndex and P SHALL all become 0.
REQ-030 HyrjaReady SHALL be 0 in every cycle in which Reset = 1.
REQ-031 Reset asserted mid-transfer SHALL discard the output word; no transfer SHALL complete in a reset cycle.

Structure
REQ-032 A shared package mux_pkg SHALL hold the default WIDTH (24), the default N, the index-width function and the mode constants MODE_FIXED = 0 and MODE_RR = 1.
REQ-033 Round-robin grant and pointer logic SHALL be a sub-module rr_arbiter (N, request vector, enable -> one-hot grant, index).
REQ-034 The output register and fixed-mode select SHALL reside in mux_arb_nto1.

Verification
REQ-035 Fixed mode, N=4, S=2, HyrjaValid=0100, ch2=0xABCDEF, DaljaReady=1 -> next cycle Dalja=0xABCDEF, DaljaIndex=2, DaljaValid=1.
REQ-036 Fixed mode, S=1, HyrjaValid=0001 -> HyrjaReady=0000, DaljaValid stays 0.
REQ-037 RR mode, HyrjaValid=1111 held, DaljaReady=1 -> DaljaIndex sequence 0,1,2,3,0 on consecutive cycles; one word per cycle.
REQ-038 RR mode, DaljaValid=1 with DaljaReady=0 for 3 cycles -> Dalja stable, HyrjaReady=0000; DaljaReady=1 -> drain and refill in the same cycle.
REQ-039 RR mode, HyrjaValid=1010, P=0 -> grant ch1, then P=2 -> grant ch3, then wrap to ch1.
REQ-040 Reset asserted while DaljaValid=1 -> next edge DaljaValid=0, Dalja=0, P=0; first grant after release is the lowest valid channel.

Source files
------------

// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
// Shared constants and helpers for the N-to-1 arbitrating multiplexer.
//   DEFAULT_WIDTH : channel data width (matches the CPU datapath)
//   DEFAULT_N     : default number of input channels
//   idxWidth()    : width of a channel index, never less than one bit
//   MODE_FIXED    : Mode value selecting the channel addressed by S
//   MODE_RR       : Mode value selecting round-robin over valid channels
// ---------------------------------------------------------------------------
package mux_pkg;

    localparam int DEFAULT_WIDTH = 24;
    localparam int DEFAULT_N     = 4;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // A two-channel mux still needs a one-bit index, so clamp at 1.
    function automatic int idxWidth(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/mux_arb_nto1_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin grant with a rotating priority pointer.
//   clk_i    : clock
//   reset_i  : synchronous active-high reset, returns the pointer to 0
//   req_i    : request vector, one bit per channel
//   enable_i : arbitration allowed this cycle; a grant issued while enabled
//              is an accepted transfer and advances the pointer
//   grant_o  : one-hot grant (all zero when disabled or no request)
//   index_o  : binary index of the granted channel
// ---------------------------------------------------------------------------
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N  = DEFAULT_N,
    localparam int IW = idxWidth(N)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic [N-1:0]  req_i,
    input  logic          enable_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] index_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    // Search upward from the pointer, wrapping past N-1 back to 0. The
    // pointer is always below N, so a single subtraction keeps the
    // candidate in range. The first requester found wins.
    always_comb begin
        int  cand;
        logic found;
        grant_o = '0;
        index_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        cand    = 0;
        for (int off = 0; off < N; off++) begin
            cand = int'(ptr_q) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && enable_i && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                index_o       = IW'(cand);
            end
        end
        // Next search starts just past the winner so it gets lowest priority.
        if (found) begin
            if (int'(index_o) == N - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = index_o + IW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mux_arb_nto1.sv
// ---------------------------------------------------------------------------
// mux_arb_nto1
// N-to-1 valid/ready multiplexer with a registered output stage. A channel
// is chosen either by the S input (fixed mode) or by a round-robin arbiter
// over the valid channels; the chosen word is captured into Dalja.
//   Clock       : sole clock
//   Reset       : synchronous active-high reset
//   Hyrja       : flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   HyrjaValid  : per-channel valid
//   HyrjaReady  : per-channel ready (combinational, at most one bit high)
//   S           : channel select for fixed mode
//   Mode        : MODE_FIXED or MODE_RR
//   Dalja       : registered selected data
//   DaljaValid  : Dalja holds an unconsumed word
//   DaljaReady  : downstream accepts Dalja this cycle
//   DaljaIndex  : channel that produced the current Dalja
// ---------------------------------------------------------------------------
module mux_arb_nto1
    import mux_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int N     = DEFAULT_N,
    localparam int IW    = idxWidth(N)
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [N*WIDTH-1:0] Hyrja,
    input  logic [N-1:0]       HyrjaValid,
    output logic [N-1:0]       HyrjaReady,
    input  logic [IW-1:0]      S,
    input  logic               Mode,
    output logic [WIDTH-1:0]   Dalja,
    output logic               DaljaValid,
    input  logic               DaljaReady,
    output logic [IW-1:0]      DaljaIndex
);

    logic [WIDTH-1:0] dalja_q,      dalja_d;
    logic             daljaValid_q, daljaValid_d;
    logic [IW-1:0]    daljaIndex_q, daljaIndex_d;

    logic             loadEnable;
    logic             rrEnable;
    logic [N-1:0]     rrGrant;
    logic [IW-1:0]    rrIndex;
    logic [N-1:0]     fixedGrant;
    logic [N-1:0]     grant;
    logic             accept;
    logic [WIDTH-1:0] selData;
    logic [IW-1:0]    selIndex;

    // The output register can take a new word when empty or when its
    // current word leaves this same cycle, giving one word per cycle.
    assign loadEnable = !daljaValid_q || DaljaReady;

    // The arbiter pointer only moves on round-robin accepts, never in
    // fixed mode and never during reset.
    assign rrEnable = (Mode == MODE_RR) && loadEnable && !Reset;

    rr_arbiter #(
        .N(N)
    ) uArbiter (
        .clk_i    (Clock),
        .reset_i  (Reset),
        .req_i    (HyrjaValid),
        .enable_i (rrEnable),
        .grant_o  (rrGrant),
        .index_o  (rrIndex)
    );

    // Fixed mode: only the addressed channel can be granted; an S value
    // outside 0..N-1 matches no channel and so grants nothing.
    always_comb begin
        fixedGrant = '0;
        for (int i = 0; i < N; i++) begin
            if ((Mode == MODE_FIXED) && (int'(S) == i) && HyrjaValid[i]) begin
                fixedGrant[i] = 1'b1;
            end
        end
    end

    assign grant      = (Mode == MODE_RR) ? rrGrant : fixedGrant;
    assign HyrjaReady = grant & {N{loadEnable && !Reset}};
    assign accept     = |HyrjaReady;
    assign selIndex   = (Mode == MODE_RR) ? rrIndex : S;

    // HyrjaReady is one-hot or zero, so an OR-reduction acts as the mux.
    always_comb begin
        selData = '0;
        for (int i = 0; i < N; i++) begin
            if (HyrjaReady[i]) begin
                selData = selData | Hyrja[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output stage: capture on accept, empty when drained with nothing
    // new, otherwise hold the registered word and its index.
    always_comb begin
        dalja_d      = dalja_q;
        daljaValid_d = daljaValid_q;
        daljaIndex_d = daljaIndex_q;
        if (accept) begin
            dalja_d      = selData;
            daljaValid_d = 1'b1;
            daljaIndex_d = selIndex;
        end else if (DaljaReady) begin
            daljaValid_d = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            dalja_q      <= '0;
            daljaValid_q <= 1'b0;
            daljaIndex_q <= '0;
        end else begin
            dalja_q      <= dalja_d;
            daljaValid_q <= daljaValid_d;
            daljaIndex_q <= daljaIndex_d;
        end
    end

    assign Dalja      = dalja_q;
    assign DaljaValid = daljaValid_q;
    assign DaljaIndex = daljaIndex_q;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// ---------------------------------------------------------------------------
// tb_mux_arb_nto1
// Self-checking bench for mux_arb_nto1 with four 24-bit channels: a
// cycle-by-cycle vector table for the directed scenarios, then randomized
// traffic compared against a behavioural model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_mux_arb_nto1;

    localparam int WIDTH = 24;
    localparam int N     = 4;
    localparam int IW    = 2;

    logic               Clock;
    logic               Reset;
    logic [N*WIDTH-1:0] Hyrja;
    logic [N-1:0]       HyrjaValid;
    logic [N-1:0]       HyrjaReady;
    logic [IW-1:0]      S;
    logic               Mode;
    logic [WIDTH-1:0]   Dalja;
    logic               DaljaValid;
    logic               DaljaReady;
    logic [IW-1:0]      DaljaIndex;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] chData [N];

    typedef struct {
        logic             rst;
        logic             mode;
        logic [IW-1:0]    s;
        logic [N-1:0]     valid;
        logic             drdy;
        logic [N-1:0]     expReady;
        logic             expValid;
        logic             chk;
        logic [IW-1:0]    expIdx;
        logic [WIDTH-1:0] expData;
    } vec_t;

    vec_t tbl[$];

    mux_arb_nto1 #(
        .WIDTH(WIDTH),
        .N(N)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Hyrja      (Hyrja),
        .HyrjaValid (HyrjaValid),
        .HyrjaReady (HyrjaReady),
        .S          (S),
        .Mode       (Mode),
        .Dalja      (Dalja),
        .DaljaValid (DaljaValid),
        .DaljaReady (DaljaReady),
        .DaljaIndex (DaljaIndex)
    );

    // Free-running 10-unit clock.
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic mode, input logic [IW-1:0] s,
                                 input logic [N-1:0] valid, input logic drdy);
        Reset      = rst;
        Mode       = mode;
        S          = s;
        HyrjaValid = valid;
        DaljaReady = drdy;
        for (int i = 0; i < N; i++) begin
            Hyrja[i*WIDTH +: WIDTH] = chData[i];
        end
    endtask

    // Per-cycle rows: inputs, HyrjaReady expected in that cycle, and the
    // registered outputs expected just after the following edge.
    task automatic loadTable();
        // reset
        tbl.push_back('{1'b1, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 24'h000000});
        // fixed, S=1 but only ch0 valid: nothing happens
        tbl.push_back('{1'b0, 1'b0, 2'd1, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 24'h000000});
        // fixed, S=2, ch2 valid
        tbl.push_back('{1'b0, 1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 24'hABCDEF});
        // drained with no new grant
        tbl.push_back('{1'b0, 1'b0, 2'd2, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 24'h000000});
        // empty register loads even though downstream stalls
        tbl.push_back('{1'b0, 1'b0, 2'd3, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1, 2'd3, 24'h444444});
        // stalled: S change must not disturb the held word
        tbl.push_back('{1'b0, 1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 24'h444444});
        // stalled: Mode change too
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 24'h444444});
        // round-robin over all-valid: 0,1,2,3,0
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 24'h111111});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 24'h222222});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 24'hABCDEF});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 24'h444444});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 24'h111111});
        // three-cycle stall, then drain and refill together
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 24'h111111});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 24'h111111});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 24'h111111});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 24'h222222});
        // reset to P=0, then sparse requesters 1010: ch1, ch3, ch1
        tbl.push_back('{1'b1, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 24'h000000});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 24'h222222});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 24'h444444});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 24'h222222});
        // stall with word held (P now 2), then reset clears everything
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 24'h222222});
        tbl.push_back('{1'b1, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 24'h000000});
        // first grant after release is the lowest valid channel
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'b0110, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 24'h222222});
    endtask

    // Behavioural model state for the random phase.
    logic             mValid;
    logic [WIDTH-1:0] mData;
    logic [IW-1:0]    mIdx;
    int               mPtr;
    logic [N-1:0]     srcValid;

    initial begin
        logic             rst;
        logic             mode;
        logic [IW-1:0]    s;
        logic             drdy;
        logic             le;
        int               g;
        int               idx;
        logic [N-1:0]     expReady;

        chData[0] = 24'h111111;
        chData[1] = 24'h222222;
        chData[2] = 24'hABCDEF;
        chData[3] = 24'h444444;
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
        repeat (2) @(posedge Clock);
        #1;

        loadTable();
        foreach (tbl[k]) begin
            applyStimulus(tbl[k].rst, tbl[k].mode, tbl[k].s, tbl[k].valid, tbl[k].drdy);
            #2;
            checkOutput($sformatf("vec%0d HyrjaReady", k), 32'(HyrjaReady), 32'(tbl[k].expReady));
            @(posedge Clock);
            #1;
            checkOutput($sformatf("vec%0d DaljaValid", k), 32'(DaljaValid), 32'(tbl[k].expValid));
            if (tbl[k].chk) begin
                checkOutput($sformatf("vec%0d DaljaIndex", k), 32'(DaljaIndex), 32'(tbl[k].expIdx));
                checkOutput($sformatf("vec%0d Dalja", k), 32'(Dalja), 32'(tbl[k].expData));
            end
        end

        // Random phase: start from a clean reset so the model matches.
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
        @(posedge Clock);
        #1;
        mValid = 1'b0;
        mData  = '0;
        mIdx   = '0;
        mPtr   = 0;
        for (int i = 0; i < N; i++) begin
            chData[i]   = WIDTH'($urandom);
            srcValid[i] = 1'($urandom);
        end
        mode = 1'b1;

        for (int cyc = 0; cyc < 600; cyc++) begin
            rst  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 15) == 0) begin
                mode = ~mode;
            end
            s    = IW'($urandom);
            drdy = ($urandom_range(0, 3) != 0);
            applyStimulus(rst, mode, s, srcValid, drdy);

            // Expected grant from the arbitration rules.
            le = !mValid || drdy;
            g  = -1;
            if (!rst && le) begin
                if (!mode) begin
                    if (int'(s) < N && srcValid[s]) begin
                        g = int'(s);
                    end
                end else begin
                    for (int off = 0; off < N; off++) begin
                        idx = (mPtr + off) % N;
                        if (g < 0 && srcValid[idx]) begin
                            g = idx;
                        end
                    end
                end
            end
            expReady = '0;
            if (g >= 0) begin
                expReady[g] = 1'b1;
            end
            #2;
            checkOutput($sformatf("rnd%0d HyrjaReady", cyc), 32'(HyrjaReady), 32'(expReady));

            @(posedge Clock);
            #1;
            if (rst) begin
                mValid = 1'b0;
                mData  = '0;
                mIdx   = '0;
                mPtr   = 0;
            end else if (g >= 0) begin
                mValid = 1'b1;
                mData  = chData[g];
                mIdx   = IW'(g);
                if (mode) begin
                    mPtr = (g + 1) % N;
                end
            end else if (drdy) begin
                mValid = 1'b0;
            end

            checkOutput($sformatf("rnd%0d DaljaValid", cyc), 32'(DaljaValid), 32'(mValid));
            if (mValid || rst) begin
                checkOutput($sformatf("rnd%0d DaljaIndex", cyc), 32'(DaljaIndex), 32'(mIdx));
                checkOutput($sformatf("rnd%0d Dalja", cyc), 32'(Dalja), 32'(mData));
            end

            // Sources keep their word until it is taken, then offer a new one.
            if (g >= 0) begin
                chData[g]   = WIDTH'($urandom);
                srcValid[g] = 1'($urandom);
            end
            for (int i = 0; i < N; i++) begin
                if (!srcValid[i] && $urandom_range(0, 2) == 0) begin
                    srcValid[i] = 1'b1;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
